// File: rtl/rtc_bus_pkg.sv
// rtl/rtc_bus_pkg.sv - shared state encoding and default address map for the RTC bus controller
package rtc_bus_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DECODE  = 3'd1,
        WR_REQ  = 3'd2,
        RD_REQ  = 3'd3,
        RD_HOLD = 3'd4,
        DONE    = 3'd5
    } rtc_state_t;

    localparam int unsigned DEF_DW        = 8;
    localparam int unsigned DEF_AW        = 8;
    localparam int unsigned DEF_IDX_W     = 4;
    localparam logic [7:0]  DEF_TIME_BASE = 8'h21;
    localparam int unsigned DEF_TIME_N    = 6;
    localparam logic [7:0]  DEF_DATE_BASE = 8'h41;
    localparam int unsigned DEF_DATE_N    = 3;
    localparam logic [7:0]  DEF_LOC0      = 8'h0A;
    localparam logic [7:0]  DEF_LOC1      = 8'h0B;
    localparam int unsigned DEF_TO_CYC    = 255;

    // Local status registers sit directly above the date window.
    localparam int unsigned LOC0_OFS = 1;
    localparam int unsigned LOC1_OFS = 2;

endpackage

// File: rtl/rtc_addr_decode.sv
// rtl/rtc_addr_decode.sv - combinational bus address to RTC register index decoder
import rtc_bus_pkg::*;

module rtc_addr_decode #(
    parameter int unsigned    AW        = DEF_AW,
    parameter int unsigned    IDX_W     = DEF_IDX_W,
    parameter logic [AW-1:0]  TIME_BASE = AW'(DEF_TIME_BASE),
    parameter int unsigned    TIME_N    = DEF_TIME_N,
    parameter logic [AW-1:0]  DATE_BASE = AW'(DEF_DATE_BASE),
    parameter int unsigned    DATE_N    = DEF_DATE_N,
    parameter logic [AW-1:0]  LOC0      = AW'(DEF_LOC0),
    parameter logic [AW-1:0]  LOC1      = AW'(DEF_LOC1)
) (
    input  logic [AW-1:0]    dir,
    output logic [IDX_W-1:0] idx,
    output logic             loc
);

    // One extra bit so base + size never wraps around the address space.
    localparam int unsigned XW = AW + 1;

    logic [XW-1:0] addr_x;
    logic [XW-1:0] time_lo;
    logic [XW-1:0] time_hi;
    logic [XW-1:0] date_lo;
    logic [XW-1:0] date_hi;
    logic          time_hit;
    logic          date_hit;

    assign addr_x   = {1'b0, dir};
    assign time_lo  = {1'b0, TIME_BASE};
    assign time_hi  = time_lo + XW'(TIME_N);
    assign date_lo  = {1'b0, DATE_BASE};
    assign date_hi  = date_lo + XW'(DATE_N);
    assign time_hit = (addr_x >= time_lo) && (addr_x < time_hi);
    assign date_hit = (addr_x >= date_lo) && (addr_x < date_hi);

    // Priority: time window, then date window, then the two local addresses.
    always_comb begin
        idx = '0;
        loc = 1'b0;
        if (time_hit) begin
            idx = IDX_W'(addr_x - time_lo) + IDX_W'(1);
        end else if (date_hit) begin
            idx = IDX_W'(addr_x - date_lo) + IDX_W'(TIME_N + 1);
        end else if (dir == LOC0) begin
            idx = IDX_W'(TIME_N + DATE_N + LOC0_OFS);
            loc = 1'b1;
        end else if (dir == LOC1) begin
            idx = IDX_W'(TIME_N + DATE_N + LOC1_OFS);
            loc = 1'b1;
        end
    end

endmodule

// File: rtl/control_rtc_bus_gen.sv
// rtl/control_rtc_bus_gen.sv - RTC bus controller FSM; RTC_WATCHDOG_EN adds a request watchdog
import rtc_bus_pkg::*;

module control_rtc_bus_gen #(
    parameter int unsigned    DW        = DEF_DW,
    parameter int unsigned    AW        = DEF_AW,
    parameter int unsigned    IDX_W     = DEF_IDX_W,
    parameter logic [AW-1:0]  TIME_BASE = AW'(DEF_TIME_BASE),
    parameter int unsigned    TIME_N    = DEF_TIME_N,
    parameter logic [AW-1:0]  DATE_BASE = AW'(DEF_DATE_BASE),
    parameter int unsigned    DATE_N    = DEF_DATE_N,
    parameter logic [AW-1:0]  LOC0      = AW'(DEF_LOC0),
    parameter logic [AW-1:0]  LOC1      = AW'(DEF_LOC1),
    parameter int unsigned    TO_CYC    = DEF_TO_CYC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             writestrobe,
    input  logic             readstrobe,
    input  logic [AW-1:0]    dir,
    input  logic [DW-1:0]    dato,
    output logic [IDX_W-1:0] dirmem,
    output logic [DW-1:0]    datoreg,
    output logic             actesc,
    output logic             actlec,
    input  logic             esclisto,
    input  logic             memorialisto,
    input  logic [DW-1:0]    datomem,
    output logic [DW-1:0]    datoout,
    output logic             dato_valid,
    output logic             busy,
    output logic             err
);

    rtc_state_t       state;
    logic [IDX_W-1:0] dec_idx;
    logic             dec_loc;
    logic             is_rd;
    logic             is_loc;
    logic [DW-1:0]    rdata;
    logic             wd_expire;

    // readstrobe alone decides the access type; any cs without it is a write.
    logic unused_wstb;
    assign unused_wstb = writestrobe;

    rtc_addr_decode #(
        .AW        (AW),
        .IDX_W     (IDX_W),
        .TIME_BASE (TIME_BASE),
        .TIME_N    (TIME_N),
        .DATE_BASE (DATE_BASE),
        .DATE_N    (DATE_N),
        .LOC0      (LOC0),
        .LOC1      (LOC1)
    ) u_decode (
        .dir (dir),
        .idx (dec_idx),
        .loc (dec_loc)
    );

`ifdef RTC_WATCHDOG_EN
    localparam int unsigned CW = $clog2(TO_CYC + 1);
    logic [CW-1:0] wd_cnt;

    // Count request cycles; held at zero outside the request states so each request starts fresh.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt <= '0;
        end else if (state == WR_REQ || state == RD_REQ) begin
            wd_cnt <= wd_cnt + 1'b1;
        end else begin
            wd_cnt <= '0;
        end
    end

    assign wd_expire = (state == WR_REQ || state == RD_REQ) && (wd_cnt == CW'(TO_CYC - 1));
`else
    logic unused_to;
    assign unused_to = (TO_CYC == 0);
    assign wd_expire = 1'b0;
`endif

    // Access sequencer: latch on cs, decode, handshake with the engine, hold read data until cs drops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            dirmem  <= '0;
            datoreg <= '0;
            is_rd   <= 1'b0;
            is_loc  <= 1'b0;
            rdata   <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cs) begin
                        dirmem  <= dec_idx;
                        datoreg <= dato;
                        is_rd   <= readstrobe;
                        is_loc  <= dec_loc;
                        err     <= 1'b0;
                        state   <= DECODE;
                    end
                end
                DECODE: begin
                    if (dirmem == '0) begin
                        err   <= 1'b1;
                        rdata <= '0;
                        state <= is_rd ? RD_HOLD : DONE;
                    end else if (is_rd && is_loc) begin
                        rdata <= datomem;
                        state <= RD_HOLD;
                    end else begin
                        state <= is_rd ? RD_REQ : WR_REQ;
                    end
                end
                WR_REQ: begin
                    if (esclisto) begin
                        state <= DONE;
                    end else if (wd_expire) begin
                        err   <= 1'b1;
                        state <= DONE;
                    end
                end
                RD_REQ: begin
                    if (memorialisto) begin
                        rdata <= datomem;
                        state <= RD_HOLD;
                    end else if (wd_expire) begin
                        err   <= 1'b1;
                        rdata <= '1;
                        state <= RD_HOLD;
                    end
                end
                RD_HOLD: begin
                    if (!cs) begin
                        rdata <= '0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign actesc     = (state == WR_REQ);
    assign actlec     = (state == RD_REQ);
    assign dato_valid = (state == RD_HOLD);
    assign busy       = (state != IDLE);
    assign datoout    = rdata;

endmodule

// File: tb/tb_control_rtc_bus_gen.sv
// tb/tb_control_rtc_bus_gen.sv - randomized scoreboard bench for control_rtc_bus_gen
module tb_control_rtc_bus_gen;

    localparam int TIME_BASE = 'h21;
    localparam int TIME_N    = 6;
    localparam int DATE_BASE = 'h41;
    localparam int DATE_N    = 3;
    localparam int LOC0      = 'h0A;
    localparam int LOC1      = 'h0B;
    localparam int TO_CYC    = 255;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cs = 1'b0;
    logic       writestrobe = 1'b0;
    logic       readstrobe = 1'b0;
    logic [7:0] dir = 8'h00;
    logic [7:0] dato = 8'h00;
    logic [7:0] datomem = 8'h00;
    logic       esclisto;
    logic       memorialisto;
    logic [3:0] dirmem;
    logic [7:0] datoreg;
    logic [7:0] datoout;
    logic       actesc;
    logic       actlec;
    logic       dato_valid;
    logic       busy;
    logic       err;

    control_rtc_bus_gen dut (
        .clk          (clk),
        .reset        (reset),
        .cs           (cs),
        .writestrobe  (writestrobe),
        .readstrobe   (readstrobe),
        .dir          (dir),
        .dato         (dato),
        .dirmem       (dirmem),
        .datoreg      (datoreg),
        .actesc       (actesc),
        .actlec       (actlec),
        .esclisto     (esclisto),
        .memorialisto (memorialisto),
        .datomem      (datomem),
        .datoout      (datoout),
        .dato_valid   (dato_valid),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         wr;
        bit         rd;
        bit         is_read;
        bit         timeout;
        int         idx;
        logic [7:0] wdata;
        logic [7:0] rdata;
        bit         err;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    logic [7:0] edges [8] = '{8'h20, 8'h27, 8'h40, 8'h44, 8'h00, 8'hFF, 8'h09, 8'h0C};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: address map and access outcome straight from the register map rules.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] wd, input bit rs,
                                   input logic [7:0] mem, input bit mute);
        exp_t e;
        int ai = int'(a);
        int idx;
        bit is_local;
        if (ai >= TIME_BASE && ai < TIME_BASE + TIME_N)      idx = ai - TIME_BASE + 1;
        else if (ai >= DATE_BASE && ai < DATE_BASE + DATE_N) idx = TIME_N + ai - DATE_BASE + 1;
        else if (ai == LOC0)                                 idx = TIME_N + DATE_N + 1;
        else if (ai == LOC1)                                 idx = TIME_N + DATE_N + 2;
        else                                                 idx = 0;
        is_local  = idx > TIME_N + DATE_N;
        e.idx     = idx;
        e.wdata   = wd;
        e.is_read = rs;
        e.wr      = !rs && idx != 0;
        e.rd      = rs && idx != 0 && !is_local;
        e.timeout = mute && (e.wr || e.rd);
        e.err     = (idx == 0) || e.timeout;
        e.rdata   = (idx == 0) ? 8'h00 : (e.timeout ? 8'hFF : mem);
        return e;
    endfunction

    // Engine responder: answers each request after lat cycles unless muted; also fires idle pulses on demand.
    int lat = 0;
    bit mute = 1'b0;
    int spur_req = 0;
    int spur_ack = 0;
    int rcnt = 0;
    bit pend = 1'b0;

    always @(negedge clk) begin
        esclisto     = 1'b0;
        memorialisto = 1'b0;
        if (!reset) begin
            pend = 1'b0;
        end else if (actesc || actlec) begin
            if (!pend && !mute) begin
                pend = 1'b1;
                rcnt = lat;
            end
            if (pend) begin
                if (rcnt == 0) begin
                    esclisto     = actesc;
                    memorialisto = actlec;
                    pend         = 1'b0;
                end else begin
                    rcnt--;
                end
            end
        end else if (spur_req != spur_ack) begin
            esclisto     = 1'b1;
            memorialisto = 1'b1;
            spur_ack     = spur_req;
        end
    end

    // Monitor: records one access per busy window and scores it against the queue head.
    bit         in_acc = 1'b0;
    int         c, o_req, o_last, o_done, o_val;
    bit         o_wr, o_rd;
    logic [7:0] o_vdata;

    task automatic score();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow actual=access expected=none");
            return;
        end
        e = sb.pop_front();
        chk("req_wr", 32'(o_wr), 32'(e.wr));
        chk("req_rd", 32'(o_rd), 32'(e.rd));
        chk("dirmem", 32'(dirmem), 32'(e.idx));
        chk("datoreg", 32'(datoreg), 32'(e.wdata));
        chk("valid_seen", 32'(o_val >= 0), 32'(e.is_read));
        if (e.is_read) chk("datoout", 32'(o_vdata), 32'(e.rdata));
        chk("err", 32'(err), 32'(e.err));
        chk("datoout_end", 32'(datoout), 32'h0);
        if (e.timeout) begin
            chk("wd_len", 32'(o_last - o_req + 1), 32'(TO_CYC));
        end else if (e.wr || e.rd) begin
            chk("req_rise", 32'(o_req), 32'd1);
            chk("req_fall", 32'(o_last), 32'(o_done));
            if (e.wr) chk("wr_busy_end", 32'(c - o_done), 32'd2);
            else      chk("rd_valid_lat", 32'(o_val - o_done), 32'd1);
        end else if (e.is_read) begin
            chk("fast_valid", 32'(o_val), 32'd1);
        end else begin
            chk("unmapped_wr_end", 32'(c), 32'd2);
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (!reset) begin
            in_acc = 1'b0;
        end else begin
            if (!in_acc && busy) begin
                in_acc  = 1'b1;
                c       = 0;
                o_req   = -1;
                o_last  = -1;
                o_done  = -1;
                o_val   = -1;
                o_wr    = 1'b0;
                o_rd    = 1'b0;
                o_vdata = 8'h00;
            end
            if (in_acc) begin
                if (busy) begin
                    if (actesc) o_wr = 1'b1;
                    if (actlec) o_rd = 1'b1;
                    if (actesc || actlec) begin
                        if (o_req < 0) o_req = c;
                        o_last = c;
                        if (o_done < 0 && ((actesc && esclisto) || (actlec && memorialisto))) o_done = c;
                    end
                    if (dato_valid && o_val < 0) begin
                        o_val   = c;
                        o_vdata = datoout;
                    end
                    c++;
                end else begin
                    score();
                    in_acc = 1'b0;
                end
            end
        end
    end

    task automatic wait_idle();
        for (int n = 0; n < 3000 && busy; n++) @(negedge clk);
        chk("idle_timeout", 32'(busy), 32'h0);
        @(negedge clk);
    endtask

    task automatic access(input logic [7:0] a, input logic [7:0] wd, input bit rs, input bit ws,
                          input logic [7:0] mem, input int l, input int hold, input bit mu);
        sb.push_back(model(a, wd, rs, mem, mu));
        mute = mu;
        lat  = l;
        @(negedge clk);
        dir         = a;
        dato        = wd;
        readstrobe  = rs;
        writestrobe = ws;
        datomem     = mem;
        cs          = 1'b1;
        @(negedge clk);
        dir         = 8'($urandom);
        dato        = 8'($urandom);
        readstrobe  = 1'($urandom);
        writestrobe = 1'($urandom);
        if (rs) repeat (hold - 1) @(negedge clk);
        cs = 1'b0;
        wait_idle();
        mute = 1'b0;
    endtask

    // Abort an access with an asynchronous reset; rd selects a held local read instead of a pending write.
    task automatic reset_abort(input bit rd);
        mute = 1'b1;
        @(negedge clk);
        dir         = rd ? 8'h0A : 8'h24;
        dato        = 8'h3C;
        readstrobe  = rd;
        writestrobe = !rd;
        datomem     = 8'hA5;
        cs          = 1'b1;
        @(negedge clk);
        if (!rd) cs = 1'b0;
        for (int n = 0; n < 20 && !(rd ? dato_valid : actesc); n++) @(negedge clk);
        if (rd) chk("rst_pre_datoout", 32'(datoout), 32'hA5);
        else    chk("rst_pre_actesc", 32'(actesc), 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("rst_actesc", 32'(actesc), 32'h0);
        chk("rst_actlec", 32'(actlec), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_datoout", 32'(datoout), 32'h0);
        chk("rst_valid", 32'(dato_valid), 32'h0);
        cs = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        mute  = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        logic [7:0] a;
        int cat;
        bit rs;
        bit ws;

        @(negedge clk);
        #1;
        chk("reset_dirmem", 32'(dirmem), 32'h0);
        chk("reset_datoreg", 32'(datoreg), 32'h0);
        chk("reset_actesc", 32'(actesc), 32'h0);
        chk("reset_actlec", 32'(actlec), 32'h0);
        chk("reset_datoout", 32'(datoout), 32'h0);
        chk("reset_valid", 32'(dato_valid), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_err", 32'(err), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        access(8'h23, 8'h45, 1'b0, 1'b1, 8'h00, 0, 1, 1'b0);
        access(8'h42, 8'h00, 1'b1, 1'b0, 8'h17, 2, 4, 1'b0);
        access(8'h0B, 8'h5A, 1'b1, 1'b0, 8'h3C, 0, 2, 1'b0);
        access(8'h21, 8'h99, 1'b1, 1'b1, 8'h66, 1, 1, 1'b0);
        access(8'h50, 8'h11, 1'b1, 1'b0, 8'h77, 0, 2, 1'b0);
        access(8'h50, 8'h22, 1'b0, 1'b1, 8'h77, 0, 1, 1'b0);
        access(8'h26, 8'h81, 1'b0, 1'b1, 8'h00, 3, 1, 1'b0);
`ifdef RTC_WATCHDOG_EN
        access(8'h42, 8'h00, 1'b1, 1'b0, 8'h12, 0, 1, 1'b1);
        access(8'h25, 8'h34, 1'b0, 1'b1, 8'h00, 0, 1, 1'b1);
`endif

        reset_abort(1'b0);
        access(8'h24, 8'hC3, 1'b0, 1'b1, 8'h00, 1, 1, 1'b0);
        reset_abort(1'b1);
        access(8'h0A, 8'h00, 1'b1, 1'b0, 8'h5E, 0, 1, 1'b0);

        for (int i = 0; i < 80; i++) begin
            cat = $urandom_range(0, 4);
            case (cat)
                0:       a = 8'(TIME_BASE + $urandom_range(0, TIME_N - 1));
                1:       a = 8'(DATE_BASE + $urandom_range(0, DATE_N - 1));
                2:       a = ($urandom_range(0, 1) == 0) ? 8'(LOC0) : 8'(LOC1);
                3:       a = edges[$urandom_range(0, 7)];
                default: a = 8'($urandom);
            endcase
            rs = 1'($urandom);
            ws = 1'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                spur_req++;
                repeat (2) @(negedge clk);
            end
            access(a, 8'($urandom), rs, ws, 8'($urandom), $urandom_range(0, 4), $urandom_range(1, 5), 1'b0);
        end

        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_rtc_bus_gen.md
# control_rtc_bus_gen

Parametrised successor to the RTC bus controller. It sits between the processor port bus (cs/strobes/address/data) and the RTC register engine. It decodes a processor address into an RTC register index, runs a request/done handshake with the write or read engine, and returns read data to the bus. Compared with the previous generation it adds configurable address windows and data width, a busy/error status, a registered read-valid, and an optional handshake watchdog.

## Interface
- DW, 8, data width of the bus and the RTC registers
- AW, 8, processor address width
- IDX_W, 4, register index width; must satisfy 2 + TIME_N + DATE_N < 2**IDX_W
- TIME_BASE, 8'h21, first time-window address
- TIME_N, 6, time-window size; maps to indices 1..TIME_N
- DATE_BASE, 8'h41, first date-window address
- DATE_N, 3, date-window size; maps to indices TIME_N+1..TIME_N+DATE_N
- LOC0 / LOC1, 8'h0A / 8'h0B, local status addresses; map to indices TIME_N+DATE_N+1 and +2
- TO_CYC, 255, watchdog limit in cycles

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- cs  in  1  bus access strobe, sampled in IDLE
- writestrobe / readstrobe  in  1  access type
- dir  in  AW  bus address
- dato  in  DW  bus write data
- dirmem  out  IDX_W  decoded register index, held for the whole access
- datoreg  out  DW  latched write data to the engine
- actesc / actlec  out  1  write / read request, level
- esclisto / memorialisto  in  1  write / read done, one-cycle pulse
- datomem  in  DW  engine read data
- datoout  out  DW  read data to the bus
- dato_valid  out  1  datoout is valid
- busy  out  1  high in every state except IDLE
- err  out  1  sticky watchdog/unmapped-access flag

## Operation
- Reset values: all outputs are 0; state is IDLE.
- IDLE to DECODE: when cs=1. dir and dato are latched, the index is decoded, and err is cleared.
- Access type: if readstrobe=1 the access is a read, even when writestrobe is also 1. Otherwise it is a write.
- Unmapped address (index 0):
  - a write goes straight to DONE with no request;
  - a read goes to RD_HOLD with datoout=0;
  - in both cases err is set.
- Local index (LOC0/LOC1):
  - a read skips the handshake, captures datomem directly, and goes to RD_HOLD;
  - a write goes to WR_REQ.
- WR_REQ: actesc=1 until esclisto is seen, then go to DONE.
- RD_REQ: actlec=1 until memorialisto is seen. datomem is captured in the same cycle, then go to RD_HOLD.
- RD_HOLD:
  - dato_valid=1 and datoout holds the captured data;
  - stay while cs=1;
  - when cs=0, go to DONE (minimum one cycle in RD_HOLD).
- DONE: datoout=0 and dato_valid=0, then go to IDLE. busy falls on entry to IDLE.
- cs activity outside IDLE is ignored; there is no queueing.

## Timing
- A write request rises 2 cycles after the cs sample edge and falls in the cycle after done is seen.
- A read request rises 2 cycles after the cs sample edge. dato_valid rises 1 cycle after memorialisto.
- A local-register read shows dato_valid 2 cycles after the cs sample edge.
- A done pulse arriving while no request is active is ignored.
- Reset asserted mid-access drops requests and all outputs asynchronously. After reset deasserts, the block resumes in IDLE.
- Index arithmetic, time window: index = dir − TIME_BASE + 1, valid only when TIME_BASE ≤ dir < TIME_BASE + TIME_N.
- Index arithmetic, date window: same rule, offset by TIME_N.
- The comparisons are unsigned, at AW width, with no wrap-around. Windows are assumed not to overlap; if they do, time has priority over date, and date over local.

## Configuration
- RTC_WATCHDOG_EN defined:
  - a counter with width $clog2(TO_CYC+1) starts on entry to WR_REQ/RD_REQ;
  - if done is not seen after TO_CYC cycles, the request drops and err is set;
  - a write then goes to DONE;
  - a read goes to RD_HOLD with datoout = all ones.
- RTC_WATCHDOG_EN undefined: no counter; requests wait indefinitely for done.

## Structure
- Shared package rtc_bus_pkg holds:
  - the state enum (IDLE, DECODE, WR_REQ, RD_REQ, RD_HOLD, DONE);
  - the default window constants;
  - the local-index offsets.
- Sub-module rtc_addr_decode is a purely combinational dir-to-index decoder with the same window parameters. The main FSM and datapath live in the top module.

## Test plan
- Write to dir=8'h23, dato=8'h45 → dirmem=3, datoreg=8'h45; actesc is high until the esclisto pulse; busy returns low 2 cycles after esclisto.
- Read from dir=8'h42; memorialisto pulses with datomem=8'h17 → dirmem=8, datoout=8'h17 with dato_valid=1 until cs=0, then datoout=0.
- Read from dir=8'h0B → no actlec; datoout equals datomem 2 cycles after cs; dirmem=11.
- writestrobe and readstrobe both 1 at dir=8'h21 → read path only; actesc never asserts.
- Read from unmapped dir=8'h50 → err=1, datoout=0, no request. With RTC_WATCHDOG_EN defined and no memorialisto: actlec drops after 255 cycles, datoout=8'hFF, err=1.
- reset=0 while actesc=1 → actesc, busy and datoout are 0 immediately (asynchronously). The next access after reset completes normally.
